uart_alu_sequencer: RTL and testbench

Frame-level controller between the UART receiver/transmitter and the ALU.
- Parses 2-byte command frames from the RX byte stream: a header byte, then a payload byte.
- Holds the ALU operands and opcode, and fires the ALU once per operation frame.
- Captures the ALU result and sends it back through the UART TX with a start/done handshake.
- Abandons stalled frames on timeout and flags malformed or overrunning traffic.

---
 rtl/uart_alu_pkg.sv | 34 +++
 rtl/uart_alu_sequencer_timer.sv | 40 ++++
 rtl/uart_alu_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the UART/ALU frame sequencer:
//   - default data and opcode widths
//   - header byte codes that open a command frame
//   - one-hot sequencer state encoding
//   - frame type latched from the header byte
// -----------------------------------------------------------------------------
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [7:0] HDR_A  = 8'h08;
  localparam logic [7:0] HDR_B  = 8'h10;
  localparam logic [7:0] HDR_OP = 8'h20;

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    DATA    = 7'b0000010,
    EXEC    = 7'b0000100,
    CAPTURE = 7'b0001000,
    TX_REQ  = 7'b0010000,
    TX_WAIT = 7'b0100000,
    ERR     = 7'b1000000
  } SeqState;

  typedef enum logic [1:0] {
    FRM_A  = 2'd0,
    FRM_B  = 2'd1,
    FRM_OP = 2'd2
  } FrameType;

endpackage

// File: rtl/uart_alu_sequencer_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Idle-cycle counter used to abandon a frame whose payload never arrives.
// Ports:
//   clk        system clock
//   i_rst      asynchronous active-high reset
//   i_clear    synchronous clear back to zero
//   i_enable   count one cycle
//   o_expired  high while the count sits at TMO_MAX-1
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int NB_TMO  = 20,
  parameter int TMO_MAX = 1000000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [NB_TMO-1:0] LAST = NB_TMO'(TMO_MAX - 1);

  logic [NB_TMO-1:0] r_count;

  // Count enabled idle cycles; hold at the last value so expiry stays
  // asserted rather than wrapping if the owner lingers for a cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + NB_TMO'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
// Parses 2-byte command frames (header + payload) from the UART RX stream,
// holds ALU operands/opcode, fires the ALU once per operation frame and
// returns the result through the UART TX with a start/done handshake.
// Ports:
//   clk, i_rst                  clock, asynchronous active-high reset
//   i_rx_data, i_rx_done        received byte and its one-cycle strobe
//   i_tx_done                   TX finished the requested byte
//   i_alu_result                external ALU output
//   o_datoA, o_datoB, o_op      operand and opcode registers
//   o_alu_valid                 one-cycle ALU execute pulse
//   o_tx_start, o_tx_data       TX request pulse and result byte
//   o_busy                      high from EXEC through TX_WAIT
//   o_frame_err                 one-cycle error pulse
// -----------------------------------------------------------------------------
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_TMO  = 20,
  parameter int TMO_MAX = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_valid,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_frame_err
);

  SeqState             r_state;
  SeqState             w_nextState;
  FrameType            r_frame;
  FrameType            w_hdrType;
  logic                w_hdrValid;
  logic                w_hdrAccept;
  logic                w_loadA;
  logic                w_loadB;
  logic                w_loadOp;
  logic                w_busy;
  logic                w_expired;
  logic                r_overrun;
  logic [NB_DATA-1:0]  r_datoA;
  logic [NB_DATA-1:0]  r_datoB;
  logic [NB_OP-1:0]    r_op;
  logic [NB_DATA-1:0]  r_txData;

  assign w_busy = (r_state == EXEC) || (r_state == CAPTURE) ||
                  (r_state == TX_REQ) || (r_state == TX_WAIT);

  // The timer is held at zero outside DATA, so entering DATA always starts
  // a fresh timeout window. A cycle carrying a byte does not count as idle.
  frame_timer #(
    .NB_TMO  (NB_TMO),
    .TMO_MAX (TMO_MAX)
  ) u_timer (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_clear   (r_state != DATA),
    .i_enable  ((r_state == DATA) && !i_rx_done),
    .o_expired (w_expired)
  );

  // Next-state and register-load decisions. A payload byte arriving on the
  // expiry cycle is checked before the timeout so the byte wins.
  always_comb begin
    w_nextState = r_state;
    w_hdrAccept = 1'b0;
    w_loadA     = 1'b0;
    w_loadB     = 1'b0;
    w_loadOp    = 1'b0;
    w_hdrValid  = 1'b1;
    w_hdrType   = FRM_A;
    if (i_rx_data == NB_DATA'(HDR_A)) begin
      w_hdrType = FRM_A;
    end else if (i_rx_data == NB_DATA'(HDR_B)) begin
      w_hdrType = FRM_B;
    end else if (i_rx_data == NB_DATA'(HDR_OP)) begin
      w_hdrType = FRM_OP;
    end else begin
      w_hdrValid = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (i_rx_done) begin
          if (w_hdrValid) begin
            w_hdrAccept = 1'b1;
            w_nextState = DATA;
          end else begin
            w_nextState = ERR;
          end
        end
      end
      DATA: begin
        if (i_rx_done) begin
          case (r_frame)
            FRM_A: begin
              w_loadA     = 1'b1;
              w_nextState = IDLE;
            end
            FRM_B: begin
              w_loadB     = 1'b1;
              w_nextState = IDLE;
            end
            FRM_OP: begin
              if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
                w_loadOp    = 1'b1;
                w_nextState = EXEC;
              end else begin
                w_nextState = ERR;
              end
            end
            default: w_nextState = ERR;
          endcase
        end else if (w_expired) begin
          w_nextState = ERR;
        end
      end
      EXEC:    w_nextState = CAPTURE;
      CAPTURE: w_nextState = TX_REQ;
      TX_REQ:  w_nextState = TX_WAIT;
      TX_WAIT: begin
        if (i_tx_done) begin
          w_nextState = IDLE;
        end
      end
      ERR:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath registers. Operands persist across frames; the result is
  // sampled one cycle after the execute pulse so either a combinational or
  // a single-cycle registered ALU is covered. Bytes arriving while busy are
  // dropped and reported one cycle later.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame   <= FRM_A;
      r_datoA   <= '0;
      r_datoB   <= '0;
      r_op      <= '0;
      r_txData  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_hdrAccept) begin
        r_frame <= w_hdrType;
      end
      if (w_loadA) begin
        r_datoA <= i_rx_data;
      end
      if (w_loadB) begin
        r_datoB <= i_rx_data;
      end
      if (w_loadOp) begin
        r_op <= i_rx_data[NB_OP-1:0];
      end
      if (r_state == CAPTURE) begin
        r_txData <= i_alu_result;
      end
      r_overrun <= i_rx_done && w_busy;
    end
  end

  // An overrun report landing on an ERR cycle merges into one pulse.
  assign o_datoA     = r_datoA;
  assign o_datoB     = r_datoB;
  assign o_op        = r_op;
  assign o_tx_data   = r_txData;
  assign o_alu_valid = (r_state == EXEC);
  assign o_tx_start  = (r_state == TX_REQ);
  assign o_busy      = w_busy;
  assign o_frame_err = (r_state == ERR) || r_overrun;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_sequencer
// Directed testbench for uart_alu_sequencer with a behavioural ALU
// (opcode 0x20 = add, 0x22 = sub). Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDone;
  logic       txDone;
  logic [7:0] aluResult;
  logic [7:0] datoA;
  logic [7:0] datoB;
  logic [5:0] op;
  logic       aluValid;
  logic       txStart;
  logic [7:0] txData;
  logic       busy;
  logic       frameErr;

  int checkCount = 0;
  int passCount  = 0;

  uart_alu_sequencer #(
    .NB_DATA (8),
    .NB_OP   (6),
    .NB_TMO  (20),
    .TMO_MAX (100)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_rx_data    (rxData),
    .i_rx_done    (rxDone),
    .i_tx_done    (txDone),
    .i_alu_result (aluResult),
    .o_datoA      (datoA),
    .o_datoB      (datoB),
    .o_op         (op),
    .o_alu_valid  (aluValid),
    .o_tx_start   (txStart),
    .o_tx_data    (txData),
    .o_busy       (busy),
    .o_frame_err  (frameErr)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Behavioural ALU: add and subtract, anything else yields zero.
  always_comb begin
    aluResult = 8'h00;
    case (op)
      6'h20:   aluResult = datoA + datoB;
      6'h22:   aluResult = datoA - datoB;
      default: aluResult = 8'h00;
    endcase
  end

  // Global bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one byte for exactly one rising edge; called and returns on a
  // falling edge so consecutive calls give back-to-back bytes.
  task automatic sendByte(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxData = 8'h00;
    rxDone = 1'b0;
    txDone = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({datoA, datoB, op, aluValid, txStart, txData, busy, frameErr} !== 36'h0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {datoA, datoB, op, aluValid, txStart, txData, busy, frameErr});
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (frameErr !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL reset_release: got err=%b busy=%b expected 0 0", frameErr, busy);
    else passCount++;
  endtask

  task automatic test_add_frame();
    int bad;
    sendByte(8'h08); sendByte(8'h05);
    sendByte(8'h10); sendByte(8'h03);
    sendByte(8'h20); sendByte(8'h20);
    checkCount++;
    if (aluValid !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL t1_alu_valid: got valid=%b busy=%b expected 1 1", aluValid, busy);
    else passCount++;
    checkCount++;
    if ({datoA, datoB, op} !== {8'h05, 8'h03, 6'h20})
      $display("[TB] FAIL t1_operands: got %h %h %h expected 05 03 20", datoA, datoB, op);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (aluValid !== 1'b0 || txStart !== 1'b0)
      $display("[TB] FAIL t1_capture: got valid=%b start=%b expected 0 0", aluValid, txStart);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (txStart !== 1'b1 || txData !== 8'h08)
      $display("[TB] FAIL t1_tx_start: got start=%b data=%h expected 1 08", txStart, txData);
    else passCount++;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txStart !== 1'b0 || busy !== 1'b1 || txData !== 8'h08) bad++;
    end
    checkCount++;
    if (bad !== 0)
      $display("[TB] FAIL t1_tx_wait_hold: got %0d bad cycles expected 0", bad);
    else passCount++;
    txDone = 1'b1;
    @(negedge clk);
    txDone = 1'b0;
    checkCount++;
    if (busy !== 1'b0 || frameErr !== 1'b0)
      $display("[TB] FAIL t1_tx_done: got busy=%b err=%b expected 0 0", busy, frameErr);
    else passCount++;
  endtask

  task automatic test_bad_header();
    sendByte(8'h55);
    checkCount++;
    if (frameErr !== 1'b1)
      $display("[TB] FAIL t2_err_pulse: got %b expected 1", frameErr);
    else passCount++;
    checkCount++;
    if ({datoA, datoB, op} !== {8'h05, 8'h03, 6'h20})
      $display("[TB] FAIL t2_regs_kept: got %h %h %h expected 05 03 20", datoA, datoB, op);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (frameErr !== 1'b0)
      $display("[TB] FAIL t2_err_single: got %b expected 0", frameErr);
    else passCount++;
    sendByte(8'h08); sendByte(8'h7F);
    checkCount++;
    if (datoA !== 8'h7F || frameErr !== 1'b0)
      $display("[TB] FAIL t2_next_frame: got A=%h err=%b expected 7f 0", datoA, frameErr);
    else passCount++;
  endtask

  task automatic test_timeout();
    int cyc;
    sendByte(8'h10);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frameErr === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checkCount++;
    if (cyc !== 100)
      $display("[TB] FAIL t3_timeout_cycle: got %0d expected 100 (0 = never)", cyc);
    else passCount++;
    checkCount++;
    if (datoB !== 8'h03 || busy !== 1'b0)
      $display("[TB] FAIL t3_regs_kept: got B=%h busy=%b expected 03 0", datoB, busy);
    else passCount++;
    @(negedge clk);
    sendByte(8'h10); sendByte(8'h05);
    checkCount++;
    if (datoB !== 8'h05 || frameErr !== 1'b0)
      $display("[TB] FAIL t3_idle_after: got B=%h err=%b expected 05 0", datoB, frameErr);
    else passCount++;
  endtask

  task automatic test_overrun();
    int bad;
    sendByte(8'h08); sendByte(8'h03);
    sendByte(8'h20); sendByte(8'h22);
    @(negedge clk);
    @(negedge clk);
    checkCount++;
    if (txStart !== 1'b1 || txData !== 8'hFE)
      $display("[TB] FAIL t4_sub_result: got start=%b data=%h expected 1 fe", txStart, txData);
    else passCount++;
    @(negedge clk);
    sendByte(8'h08);
    checkCount++;
    if (frameErr !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL t4_overrun_err: got err=%b busy=%b expected 1 1", frameErr, busy);
    else passCount++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (txStart !== 1'b0 || frameErr !== 1'b0 || busy !== 1'b1) bad++;
    end
    checkCount++;
    if (bad !== 0)
      $display("[TB] FAIL t4_no_restart: got %0d bad cycles expected 0", bad);
    else passCount++;
    checkCount++;
    if (datoA !== 8'h03 || txData !== 8'hFE)
      $display("[TB] FAIL t4_a_kept: got A=%h data=%h expected 03 fe", datoA, txData);
    else passCount++;
    txDone = 1'b1;
    @(negedge clk);
    txDone = 1'b0;
    sendByte(8'h05);
    checkCount++;
    if (frameErr !== 1'b1 || datoA !== 8'h03)
      $display("[TB] FAIL t4_dropped_byte: got err=%b A=%h expected 1 03", frameErr, datoA);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_reset_tx_wait();
    int bad;
    sendByte(8'h20); sendByte(8'h20);
    repeat (3) @(negedge clk);
    checkCount++;
    if (busy !== 1'b1 || txData !== 8'h08)
      $display("[TB] FAIL t5_in_tx_wait: got busy=%b data=%h expected 1 08", busy, txData);
    else passCount++;
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if ({datoA, datoB, op, aluValid, txStart, txData, busy, frameErr} !== 36'h0)
      $display("[TB] FAIL t5_async_reset: got %h expected 0",
               {datoA, datoB, op, aluValid, txStart, txData, busy, frameErr});
    else passCount++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txDone = 1'b1;
    @(negedge clk);
    txDone = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy !== 1'b0 || txStart !== 1'b0 || frameErr !== 1'b0 || txData !== 8'h00) bad++;
      @(negedge clk);
    end
    checkCount++;
    if (bad !== 0)
      $display("[TB] FAIL t5_late_tx_done: got %0d bad cycles expected 0", bad);
    else passCount++;
  endtask

  task automatic test_expiry_race();
    int errSeen;
    sendByte(8'h08);
    errSeen = 0;
    repeat (99) begin
      @(negedge clk);
      if (frameErr !== 1'b0) errSeen++;
    end
    checkCount++;
    if (errSeen !== 0)
      $display("[TB] FAIL t6_early_timeout: got %0d err cycles expected 0", errSeen);
    else passCount++;
    sendByte(8'h11);
    checkCount++;
    if (datoA !== 8'h11 || frameErr !== 1'b0)
      $display("[TB] FAIL t6_byte_wins: got A=%h err=%b expected 11 0", datoA, frameErr);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (frameErr !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL t6_no_err_after: got err=%b busy=%b expected 0 0", frameErr, busy);
    else passCount++;
  endtask

  // Scenarios run in order; later ones rely on operand values left by
  // earlier ones (A=0x03, B=0x05 going into the subtract frame).
  initial begin
    test_reset();
    test_add_frame();
    test_bad_header();
    test_timeout();
    test_overrun();
    test_reset_tx_wait();
    test_expiry_race();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
